// File: rtl/uart_frame_parser.sv
// Framed-packet extractor for the uart_recv byte stream: 0x55 0xAA LEN PAYLOAD[LEN] CSUM.
// Payload is streamed as it arrives; each frame ends with a frame_ok or frame_err pulse.
module uart_frame_parser #(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] in_dat,
  input  logic       in_flag,
  output logic [7:0] pl_dat,
  output logic       pl_valid,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR2    = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    pl_dat_q, pl_dat_d;
  logic          pl_valid_q, pl_valid_d;
  logic          pl_last_q, pl_last_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          timed_s;

  assign timed_s = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

  // Next-state logic: a received byte always takes priority over the inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    pl_dat_d    = pl_dat_q;
    pl_valid_d  = 1'b0;
    pl_last_d   = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    if (in_flag) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (in_dat == 8'h55) state_d = S_HDR2;
          else                 state_d = S_IDLE;
        end
        S_HDR2: begin
          if (in_dat == 8'hAA)      state_d = S_LEN;
          else if (in_dat == 8'h55) state_d = S_HDR2;
          else                      state_d = S_IDLE;
        end
        S_LEN: begin
          if ((in_dat == 8'd0) || (in_dat > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = S_IDLE;
          end else begin
            len_d   = in_dat;
            sum_d   = in_dat;
            cnt_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          pl_dat_d   = in_dat;
          pl_valid_d = 1'b1;
          sum_d      = sum_q + in_dat;
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q == (len_q - 8'd1)) begin
            pl_last_d = 1'b1;
            state_d   = S_CSUM;
          end else begin
            state_d   = S_PAYLOAD;
          end
        end
        S_CSUM: begin
          if (in_dat == sum_q) begin
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timed_s) begin
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = 2'd3;
        state_d     = S_IDLE;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // State and output registers; reset drops any frame in progress without an error pulse.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      cnt_q       <= 8'd0;
      sum_q       <= 8'd0;
      tmo_q       <= '0;
      pl_dat_q    <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      pl_dat_q    <= pl_dat_d;
      pl_valid_q  <= pl_valid_d;
      pl_last_q   <= pl_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign pl_dat    = pl_dat_q;
  assign pl_valid  = pl_valid_q;
  assign pl_last   = pl_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus queues expected events, a monitor pops them.
module tb_uart_frame_parser;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_dat = 8'd0;
  logic       in_flag = 1'b0;
  logic [7:0] pl_dat;
  logic       pl_valid, pl_last, frame_ok, frame_err, busy;
  logic [1:0] err_code;

  uart_frame_parser #(.MAX_LEN(16), .TIMEOUT_CYC(50)) dut (
    .sys_clk(sys_clk), .rst(rst), .in_dat(in_dat), .in_flag(in_flag),
    .pl_dat(pl_dat), .pl_valid(pl_valid), .pl_last(pl_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // kind: 0 payload byte, 1 frame_ok, 2 frame_err
  typedef struct {
    int         kind;
    logic [7:0] dat;
    logic       last;
    logic [1:0] code;
    int         at;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic exp_pl(input logic [7:0] d, input logic last);
    q.push_back('{kind: 0, dat: d, last: last, code: 2'd0, at: cyc + 1});
  endtask

  task automatic exp_ok();
    q.push_back('{kind: 1, dat: 8'd0, last: 1'b0, code: 2'd0, at: cyc + 1});
  endtask

  task automatic exp_err(input logic [1:0] code, input int delay);
    q.push_back('{kind: 2, dat: 8'd0, last: 1'b0, code: code, at: cyc + delay});
  endtask

  // Caller is at a negedge; the flag stays high so consecutive sends are back-to-back.
  task automatic send(input logic [7:0] b);
    in_dat  = b;
    in_flag = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    in_flag = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  // Monitor: every observed output event must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (frame_ok && frame_err) begin
      vectors++;
      miscompares++;
      $display("FAIL ok_err_together: got both asserted at cycle %0d, expected exclusive", cyc);
    end else if (pl_valid || frame_ok || frame_err) begin
      int kind;
      exp_t e;
      kind = pl_valid ? 0 : (frame_ok ? 1 : 2);
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
        e = q.pop_front();
        if (kind != e.kind || cyc != e.at ||
            (kind == 0 && (pl_dat !== e.dat || pl_last !== e.last)) ||
            (kind != 0 && pl_last !== 1'b0) ||
            (kind == 2 && err_code !== e.code)) begin
          miscompares++;
          $display("FAIL event: got kind %0d cyc %0d dat %02h last %0b code %0d, expected kind %0d cyc %0d dat %02h last %0b code %0d",
                   kind, cyc, pl_dat, pl_last, err_code, e.kind, e.at, e.dat, e.last, e.code);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    chk("reset_pl_valid", int'(pl_valid), 0);
    chk("reset_pl_dat", int'(pl_dat), 0);
    chk("reset_err_code", int'(err_code), 0);
    chk("reset_busy", int'(busy), 0);

    // 1: good 3-byte frame
    send(8'h55); send(8'hAA); send(8'h03);
    exp_pl(8'h11, 1'b0); send(8'h11);
    exp_pl(8'h22, 1'b0); send(8'h22);
    exp_pl(8'h33, 1'b1); send(8'h33);
    exp_ok(); send(8'h69);
    idle(3);

    // 2: bad checksum
    send(8'h55); send(8'hAA); send(8'h02);
    exp_pl(8'h01, 1'b0); send(8'h01);
    exp_pl(8'h02, 1'b1); send(8'h02);
    exp_err(2'd2, 1); send(8'h00);
    idle(3);
    chk("err_code_held_csum", int'(err_code), 2);

    // 3: LEN 0 and LEN 17 rejected
    send(8'h55); send(8'hAA);
    exp_err(2'd1, 1); send(8'h00);
    idle(3);
    send(8'h55); send(8'hAA);
    exp_err(2'd1, 1); send(8'h11);
    idle(3);

    // 4: junk byte then resync on a repeated 0x55
    send(8'h12); send(8'h55); send(8'h55); send(8'hAA); send(8'h01);
    exp_pl(8'h7F, 1'b1); send(8'h7F);
    exp_ok(); send(8'h80);
    idle(3);
    chk("err_code_held_after_ok", int'(err_code), 1);

    // 5: timeout exactly 50 cycles after the last strobe
    send(8'h55); send(8'hAA); send(8'h02);
    exp_pl(8'h01, 1'b0);
    t0 = cyc;
    send(8'h01);
    q.push_back('{kind: 2, dat: 8'd0, last: 1'b0, code: 2'd3, at: t0 + 51});
    chk("busy_mid_frame", int'(busy), 1);
    idle(60);
    chk("busy_after_timeout", int'(busy), 0);
    chk("err_code_timeout", int'(err_code), 3);
    send(8'h55); send(8'hAA); send(8'h03);
    exp_pl(8'h11, 1'b0); send(8'h11);
    exp_pl(8'h22, 1'b0); send(8'h22);
    exp_pl(8'h33, 1'b1); send(8'h33);
    exp_ok(); send(8'h69);
    idle(3);

    // Boundary: a byte landing on the timeout cycle is processed instead
    send(8'h55); send(8'hAA); send(8'h01);
    idle(49);
    exp_pl(8'h09, 1'b1); send(8'h09);
    idle(49);
    exp_ok(); send(8'h0A);
    idle(3);

    // 6: reset mid-frame drops it silently
    send(8'h55); send(8'hAA); send(8'h04);
    exp_pl(8'hAB, 1'b0); send(8'hAB);
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_pl_valid", int'(pl_valid), 0);
    chk("rst_pl_last", int'(pl_last), 0);
    chk("rst_pl_dat", int'(pl_dat), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_busy", int'(busy), 0);
    send(8'h55); send(8'hAA); send(8'h01);
    exp_pl(8'h05, 1'b1); send(8'h05);
    exp_ok(); send(8'h06);
    idle(5);

    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
